// File: rtl/isolator_shift_ctrl_pkg.sv
// Shared types and helpers for the isolator shift-register chain master.
package isolator_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } frame_state_t;

    // Each slot contributes one padding/status bit and one payload bit per word.
    function automatic int frame_width(input int num_slots);
        return 2 * num_slots;
    endfunction

endpackage

// File: rtl/isolator_shift_ctrl_tick.sv
// Divides clk by SCLK_DIV into a one-clk tick; the phase restarts at every frame.
module isolator_tick_gen
    import isolator_shift_ctrl_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  frame_state_t state,
    output logic         tick
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

    logic          hold;
    logic [CW-1:0] cnt;

    assign hold = (state == ST_IDLE) || (state == ST_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (hold || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/isolator_shift_ctrl.sv
// Frames per-slot cs_n/hwcon out to the isolator chain and reads dir/chan/hwflag back.
module isolator_shift_ctrl
    import isolator_shift_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SCLK_DIV       = 4,
    parameter int REFRESH_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 force_scan,
    input  logic [NUM_SLOTS-1:0] cs_n_in,
    input  logic [NUM_SLOTS-1:0] hwcon_in,
    output logic                 sclk,
    output logic                 srclk,
    output logic                 cs_n_ser,
    output logic                 hwcon_ser,
    input  logic                 dirchan_ser,
    input  logic                 hwflag_ser,
    output logic [NUM_SLOTS-1:0] slot_dir,
    output logic [NUM_SLOTS-1:0] slot_chan,
    output logic [NUM_SLOTS-1:0] slot_hwflag,
    output logic                 status_valid,
    output logic                 status_changed,
    output logic                 busy
);

    localparam int W  = frame_width(NUM_SLOTS);
    localparam int TW = $clog2(2 * W);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam logic [TW-1:0] SHIFT_LAST = TW'(2 * W - 1);
    localparam logic [RW-1:0] REF_MAX    = RW'(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST   = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    frame_state_t         state;
    logic                 tick;
    logic [TW-1:0]        tick_cnt;
    logic [RW-1:0]        ref_cnt;
    logic                 force_pend;
    logic                 primed;
    logic [NUM_SLOTS-1:0] sent_cs;
    logic [NUM_SLOTS-1:0] sent_hw;
    logic [W-1:0]         out_cs_sr;
    logic [W-1:0]         out_hw_sr;
    logic [W-1:0]         in_dc_sr;
    logic [NUM_SLOTS-1:0] in_hf_sr;
    logic                 fall_evt;
    logic                 refresh_hit;
    logic                 trigger;

    isolator_tick_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (state),
        .tick    (tick)
    );

    // Odd tick_cnt values end an even-numbered tick: that is the sclk falling edge.
    assign fall_evt    = (state == ST_SHIFT) && tick && tick_cnt[0];
    assign refresh_hit = (REFRESH_CYCLES != 0) && (state == ST_IDLE) && (ref_cnt >= REF_LAST);
    assign trigger     = enable && ((cs_n_in != sent_cs) || (hwcon_in != sent_hw) ||
                                    force_pend || refresh_hit);

    // Shift datapath: loaded at LOAD, advanced on every sclk fall.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            out_cs_sr <= {{NUM_SLOTS{1'b1}}, cs_n_in};
            out_hw_sr <= {{NUM_SLOTS{1'b0}}, hwcon_in};
        end else if (fall_evt) begin
            out_cs_sr <= W'({out_cs_sr, 1'b1});
            out_hw_sr <= W'({out_hw_sr, 1'b0});
            in_dc_sr  <= W'({in_dc_sr, dirchan_ser});
            in_hf_sr  <= NUM_SLOTS'({in_hf_sr, hwflag_ser});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            tick_cnt       <= '0;
            ref_cnt        <= '0;
            force_pend     <= 1'b0;
            primed         <= 1'b0;
            sent_cs        <= '1;
            sent_hw        <= '0;
            sclk           <= 1'b0;
            srclk          <= 1'b0;
            cs_n_ser       <= 1'b1;
            hwcon_ser      <= 1'b0;
            slot_dir       <= '0;
            slot_chan      <= '0;
            slot_hwflag    <= '0;
            status_valid   <= 1'b0;
            status_changed <= 1'b0;
            busy           <= 1'b0;
        end else begin
            status_valid   <= 1'b0;
            status_changed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk  <= 1'b0;
                    srclk <= 1'b0;
                    if (ref_cnt != REF_MAX) begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                    if (trigger) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    sent_cs    <= cs_n_in;
                    sent_hw    <= hwcon_in;
                    // The leading half of each out word is padding: cs_n idle high, hwcon low.
                    cs_n_ser   <= 1'b1;
                    hwcon_ser  <= 1'b0;
                    force_pend <= 1'b0;
                    ref_cnt    <= '0;
                    tick_cnt   <= '0;
                    state      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        tick_cnt <= (tick_cnt == SHIFT_LAST) ? '0 : tick_cnt + 1'b1;
                        if (!tick_cnt[0]) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (tick_cnt == SHIFT_LAST) begin
                                srclk <= 1'b1;
                                state <= ST_LATCH;
                            end else begin
                                cs_n_ser  <= out_cs_sr[W-2];
                                hwcon_ser <= out_hw_sr[W-2];
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        if (tick_cnt == TW'(1)) begin
                            tick_cnt  <= '0;
                            srclk     <= 1'b0;
                            cs_n_ser  <= 1'b1;
                            hwcon_ser <= 1'b0;
                            primed    <= 1'b1;
                            // The first frame only reads back what the previous latch captured.
                            if (primed) begin
                                slot_dir       <= in_dc_sr[NUM_SLOTS-1:0];
                                slot_chan      <= in_dc_sr[W-1:NUM_SLOTS];
                                slot_hwflag    <= in_hf_sr;
                                status_valid   <= 1'b1;
                                status_changed <= (in_dc_sr != {slot_chan, slot_dir}) ||
                                                  (in_hf_sr != slot_hwflag);
                            end
                            if (trigger) begin
                                state <= ST_LOAD;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // A request arriving in the same cycle as LOAD still earns its own frame.
            if (force_scan) begin
                force_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isolator_shift_ctrl.sv
// Self-checking bench: isolator chain model, per-cycle status model and directed frame checks.
`timescale 1ns/1ps
module tb_isolator_shift_ctrl;

    localparam int N         = 4;
    localparam int W         = 2 * N;
    localparam int DIV       = 4;
    localparam int RC        = 64;
    localparam int FRAME_CLK = 1 + 2 * W * DIV + 2 * DIV;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         force_scan = 1'b0;
    logic [N-1:0] cs_n_in = '1;
    logic [N-1:0] hwcon_in = '0;
    logic         sclk, srclk, cs_n_ser, hwcon_ser;
    logic         dirchan_ser = 1'b0;
    logic         hwflag_ser = 1'b0;
    logic [N-1:0] slot_dir, slot_chan, slot_hwflag;
    logic         status_valid, status_changed, busy;

    always #5 clk = ~clk;

    isolator_shift_ctrl #(
        .NUM_SLOTS      (N),
        .SCLK_DIV       (DIV),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .force_scan     (force_scan),
        .cs_n_in        (cs_n_in),
        .hwcon_in       (hwcon_in),
        .sclk           (sclk),
        .srclk          (srclk),
        .cs_n_ser       (cs_n_ser),
        .hwcon_ser      (hwcon_ser),
        .dirchan_ser    (dirchan_ser),
        .hwflag_ser     (hwflag_ser),
        .slot_dir       (slot_dir),
        .slot_chan      (slot_chan),
        .slot_hwflag    (slot_hwflag),
        .status_valid   (status_valid),
        .status_changed (status_changed),
        .busy           (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Isolator side: parallel state, input registers loaded on srclk, receive shift chain.
    logic [N-1:0] iso_dir, iso_chan, iso_hf;
    logic [W-1:0] snap_dc = '0, snap_hf = '0, frame_dc = '0, frame_hf = '0;
    logic [W-1:0] rx_cs = '0, rx_hw = '0;
    // Expected slot outputs.
    bit           m_primed = 1'b0;
    logic [N-1:0] m_dir = '0, m_chan = '0, m_hf = '0;
    bit           exp_chg;
    // Per-frame log.
    logic [W-1:0] log_cs [32];
    logic [W-1:0] log_hw [32];
    int           log_t [32];
    int           log_rises [32];
    int           log_w [32];
    int           nfr = 0, nend = 0, rise_cnt = 0, srclk_w = 0, cyc = 0;
    int           valid_cnt = 0, changed_cnt = 0;
    bit           prev_sclk = 1'b0, prev_srclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            check("reset_outputs", 32'({sclk, srclk, cs_n_ser, hwcon_ser, busy, status_valid, status_changed}),
                  32'b0010000);
            check("reset_slots", 32'({slot_dir, slot_chan, slot_hwflag}), 32'd0);
            m_primed   = 1'b0;
            m_dir      = '0;
            m_chan     = '0;
            m_hf       = '0;
            rise_cnt   = 0;
            srclk_w    = 0;
            prev_sclk  = 1'b0;
            prev_srclk = 1'b0;
        end else begin
            if (status_valid)   valid_cnt++;
            if (status_changed) changed_cnt++;
            if (sclk && !prev_sclk) begin
                rx_cs = W'({rx_cs, cs_n_ser});
                rx_hw = W'({rx_hw, hwcon_ser});
                if (rise_cnt < W) begin
                    dirchan_ser = snap_dc[W-1-rise_cnt];
                    hwflag_ser  = snap_hf[W-1-rise_cnt];
                end
                rise_cnt++;
            end
            if (srclk && !prev_srclk) begin
                if (nfr < 32) begin
                    log_cs[nfr]    = rx_cs;
                    log_hw[nfr]    = rx_hw;
                    log_t[nfr]     = cyc;
                    log_rises[nfr] = rise_cnt;
                end
                nfr++;
                frame_dc = snap_dc;
                frame_hf = snap_hf;
                snap_dc  = {iso_chan, iso_dir};
                snap_hf  = {4'hC, iso_hf};
                rise_cnt = 0;
                srclk_w  = 0;
            end
            if (srclk) srclk_w++;
            if (!srclk && prev_srclk) begin
                if (nend < 32) log_w[nend] = srclk_w;
                nend++;
                if (m_primed) begin
                    exp_chg = ({frame_dc, frame_hf[N-1:0]} != {m_chan, m_dir, m_hf});
                    m_chan  = frame_dc[W-1:N];
                    m_dir   = frame_dc[N-1:0];
                    m_hf    = frame_hf[N-1:0];
                    check("status_valid", 32'(status_valid), 32'd1);
                    check("status_changed", 32'(status_changed), 32'(exp_chg));
                end else begin
                    check("status_unprimed", 32'({status_valid, status_changed}), 32'd0);
                end
                m_primed = 1'b1;
            end else begin
                check("status_quiet", 32'({status_valid, status_changed}), 32'd0);
            end
            check("slots", 32'({slot_dir, slot_chan, slot_hwflag}), 32'({m_dir, m_chan, m_hf}));
            if (sclk || srclk) check("busy_during_frame", 32'(busy), 32'd1);
            if (!busy) check("idle_lines", 32'({sclk, srclk, cs_n_ser, hwcon_ser}), 32'b0010);
            prev_sclk  = sclk;
            prev_srclk = srclk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ends(input int target, input int budget);
        int n = 0;
        while (nend < target && n < budget) begin
            step(1);
            n++;
        end
        check("frame_end_wait", 32'(nend >= target), 32'd1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (rise_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check("sclk_rise_wait", 32'(rise_cnt >= target), 32'd1);
    endtask

    task automatic pulse_force();
        force_scan = 1'b1;
        step(1);
        force_scan = 1'b0;
    endtask

    int v0, c0;

    initial begin
        iso_dir  = 4'h5;
        iso_chan = 4'hA;
        iso_hf   = 4'h2;
        step(3);
        reset_n = 1'b1;

        // First frame after reset: serial words and strobe shape, no status.
        cs_n_in  = 4'hE;
        hwcon_in = 4'h3;
        enable   = 1'b1;
        wait_ends(1, 200);
        check("t1_cs_word", 32'(log_cs[0]), 32'h0FE);
        check("t1_hw_word", 32'(log_hw[0]), 32'h003);
        check("t1_sclk_pulses", log_rises[0], 8);
        check("t1_srclk_width", log_w[0], 2 * DIV);
        check("t1_no_status", valid_cnt, 0);

        // Second frame returns the isolator state latched by the first.
        pulse_force();
        wait_ends(2, 200);
        check("t2_dir", 32'(slot_dir), 32'h5);
        check("t2_chan", 32'(slot_chan), 32'hA);
        check("t2_hwflag", 32'(slot_hwflag), 32'h2);
        check("t2_valid_cnt", valid_cnt, 1);
        check("t2_changed_cnt", changed_cnt, 1);

        // Periodic refresh with steady inputs.
        wait_ends(5, 600);
        check("t3_period_a", log_t[2] - log_t[1], FRAME_CLK + RC);
        check("t3_period_b", log_t[3] - log_t[2], FRAME_CLK + RC);
        check("t3_period_c", log_t[4] - log_t[3], FRAME_CLK + RC);
        check("t3_valid_cnt", valid_cnt, 4);
        check("t3_changed_cnt", changed_cnt, 1);
        check("t3_cs_word", 32'(log_cs[4]), 32'h0FE);

        // Mid-frame cs_n change is carried by a back-to-back frame.
        cs_n_in = 4'hF;
        wait_ends(6, 300);
        wait_rises(4, 300);
        cs_n_in = 4'hD;
        wait_ends(8, 400);
        check("t4_cs_word_a", 32'(log_cs[5]), 32'h0FF);
        check("t4_cs_word_b", 32'(log_cs[6]), 32'h0FF);
        check("t4_cs_word_c", 32'(log_cs[7]), 32'h0FD);
        check("t4_hw_word_c", 32'(log_hw[7]), 32'h003);
        check("t4_back_to_back", log_t[7] - log_t[6], FRAME_CLK);

        // Force while disabled is held until enable, then yields one frame.
        enable = 1'b0;
        step(100);
        check("t5_disabled_idle", nfr, 8);
        pulse_force();
        step(20);
        check("t5_force_held", nfr, 8);
        enable = 1'b1;
        step(FRAME_CLK + 40);
        check("t5_one_frame", nfr, 9);
        check("t5_one_end", nend, 9);

        // Asynchronous reset mid-shift, then an unprimed frame, then a primed one.
        iso_dir  = 4'h3;
        iso_chan = 4'hC;
        iso_hf   = 4'h9;
        cs_n_in  = 4'hB;
        wait_rises(3, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_outputs", 32'({sclk, srclk, cs_n_ser, hwcon_ser, busy, status_valid, status_changed}),
              32'b0010000);
        check("t6_async_slots", 32'({slot_dir, slot_chan, slot_hwflag}), 32'd0);
        step(3);
        reset_n = 1'b1;
        v0 = valid_cnt;
        c0 = changed_cnt;
        wait_ends(nend + 1, 200);
        check("t6_no_srclk_on_abort", nfr, 10);
        check("t6_cs_word", 32'(log_cs[9]), 32'h0FB);
        check("t6_unprimed", valid_cnt, v0);
        check("t6_slots_zero", 32'({slot_dir, slot_chan, slot_hwflag}), 32'd0);
        pulse_force();
        wait_ends(nend + 1, 200);
        check("t6_dir", 32'(slot_dir), 32'h3);
        check("t6_chan", 32'(slot_chan), 32'hC);
        check("t6_hwflag", 32'(slot_hwflag), 32'h9);
        check("t6_valid_cnt", valid_cnt, v0 + 1);
        check("t6_changed_cnt", changed_cnt, c0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/isolator_shift_ctrl.md
Name: isolator_shift_ctrl

Overview:
FPGA-side master for the isolator board's 74xx shift-register chain, generalised to NUM_SLOTS slots. Each frame serialises per-slot cs_n and hwcon out to the isolator. In the same frame it deserialises per-slot dir, chan and hwflag back in, then pulses srclk to latch both directions. It rescans automatically on any change of requested outputs, on a periodic refresh timer, or on a force request, and it reports input changes.

Parameters:
NUM_SLOTS, 4, number of slots; frame length W = 2*NUM_SLOTS bits
SCLK_DIV, 4, clk cycles per sclk half-period (tick); legal range >= 1
REFRESH_CYCLES, 4096, idle clk cycles before an automatic rescan; 0 disables periodic refresh

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  allow new frames to start
force_scan  in  1  one-cycle pulse; requests a frame
cs_n_in  in  NUM_SLOTS  requested per-slot chip selects (active low)
hwcon_in  in  NUM_SLOTS  requested per-slot hardware-control bits
sclk  out  1  serial clock to isolator
srclk  out  1  parallel latch strobe to isolator
cs_n_ser  out  1  serial cs_n data
hwcon_ser  out  1  serial hwcon data
dirchan_ser  in  1  serial {chan, dir} from isolator
hwflag_ser  in  1  serial hwflag from isolator
slot_dir  out  NUM_SLOTS  latest valid dir bits
slot_chan  out  NUM_SLOTS  latest valid chan bits
slot_hwflag  out  NUM_SLOTS  latest valid hwflag bits
status_valid  out  1  one-cycle pulse: slot_* updated
status_changed  out  1  one-cycle pulse, coincident with status_valid, when any slot_* bit differs from its previous value
busy  out  1  high from LOAD through LATCH

Behaviour:
- Reset values: sclk=0, srclk=0, cs_n_ser=1, hwcon_ser=0, slot_*=0, status_valid=0, status_changed=0, busy=0, state=IDLE, primed=0.
- Frame words, MSB first:
  - out_cs = {NUM_SLOTS ones, cs_n}
  - out_hw = {NUM_SLOTS zeros, hwcon}
  - in_dc = {chan, dir}
  - in_hf = {NUM_SLOTS pad, hwflag}; pad bits are ignored.
- States:
  - IDLE: sclk=0, srclk=0. Exit to LOAD when enable && (cs_n_in!=sent_cs || hwcon_in!=sent_hw || force pending || refresh counter hit REFRESH_CYCLES). force_scan is latched as pending until the next LOAD, even while busy or while enable=0.
  - LOAD (1 clk): snapshot cs_n_in and hwcon_in into the shift registers and into sent_cs/sent_hw; drive MSB onto cs_n_ser/hwcon_ser; clear the pending force and the refresh counter.
  - SHIFT (2W ticks): sclk rises at the end of odd ticks and falls at the end of even ticks.
    - At each falling edge, sample dirchan_ser and hwflag_ser into the input shift registers.
    - At that same clk edge, present the next out bit.
    - The isolator launches inputs on sclk rise; the block samples them on sclk fall.
  - LATCH (2 ticks): sclk=0, srclk=1. On exit, srclk=0 and the cs_n/hwcon data lines return to their idle values (1/0).
    - If primed=1: update slot_* and pulse status_valid for 1 clk; pulse status_changed when applicable. Set primed=1 in all cases.
    - Go to LOAD if a new trigger is already pending, else go to IDLE.
- Input data read in frame N reflects isolator state latched by the srclk of frame N-1. The first frame after reset therefore carries no valid status (primed gate).
- Mid-frame changes: cs_n_in/hwcon_in changes do not affect a frame already in progress. They are sent by the very next frame, with no refresh wait.
- Deasserting enable mid-frame: the frame completes; no new frame starts.
- Reset mid-frame: aborts immediately to reset values; no srclk pulse is emitted.
- Worst-case latency from a cs_n_in change to the isolator latch: 2*(1 + (2W+2)*SCLK_DIV) clk.
- Refresh counter: saturating; counts only in IDLE.

Decomposition:
- Shared package: frame-state enum (IDLE, LOAD, SHIFT, LATCH) and a function computing W from NUM_SLOTS.
- One natural sub-module: isolator_tick_gen. It is a SCLK_DIV divider producing a one-clk tick strobe, held in reset while in IDLE/LOAD so that the phase restarts every frame.

Test Plan:
1. After reset, enable=1, cs_n_in=4'hE, hwcon_in=4'h3 -> one frame of 8 sclk pulses; cs_n_ser sequence 1,1,1,1,1,1,1,0; hwcon_ser sequence 0,0,0,0,0,0,1,1; srclk high for 2*SCLK_DIV clk; no status_valid (unprimed).
2. Isolator model holding dir=4'h5, chan=4'hA, hwflag=4'h2 -> second frame gives slot_dir=5, slot_chan=A, slot_hwflag=2, with status_valid and status_changed pulsing together once.
3. No input changes with REFRESH_CYCLES=64 -> a frame every 64 idle clk plus the frame length; status_valid pulses each time; status_changed stays 0.
4. Change cs_n_in from F to D halfway through SHIFT -> the current frame still shifts F; the next LOAD follows LATCH directly and shifts D.
5. force_scan pulsed while enable=0, then enable raised 20 clk later -> exactly one frame.
6. reset_n asserted mid-SHIFT -> all outputs go to reset values asynchronously; the next frame after release is unprimed (no status_valid).
